// File: rtl/fetch_stage.sv
// Instruction fetch stage: program counter, next-PC selection and the IF/ID
// pipeline register, sequenced by a small BOOT/RUN/HALT controller.
//
// state | meaning
// ------+----------------------------------------------------------------
// BOOT  | first cycle after reset: PC pinned to RESET_PC, bubble into IF/ID
// RUN   | normal fetch: redirect > stall > PC+1, IF/ID loads or bubbles
// HALT  | halt word seen: PC frozen, bubbles each cycle, redirect resumes
//
// Optional feature macro: FETCH_HALT_DETECT_EN enables entry into HALT when
// the all-ones instruction word is fetched. Without it HALT is unreachable
// and halted_q is tied low.

`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module fetch_stage #(
    parameter logic [`MEM_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [`DATA_WIDTH-1:0]     NOP_WORD = 32'h0000_0000
) (
    input  logic                       clk_phase1_i,
    input  logic                       rst_n_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       redirect_i,
    input  logic [`MEM_ADDR_WIDTH-1:0] redirect_pc_i,
    output logic [`MEM_ADDR_WIDTH-1:0] ins_addr_o,
    input  logic [`DATA_WIDTH-1:0]     ins_data_i,
    output logic [`MEM_ADDR_WIDTH-1:0] ifid_pc_q,
    output logic [`MEM_ADDR_WIDTH-1:0] ifid_pc_plus1_q,
    output logic [`DATA_WIDTH-1:0]     ifid_ins_q,
    output logic                       ifid_valid_q,
    output logic                       halted_q
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                     state_q;
    logic [`MEM_ADDR_WIDTH-1:0] pc_q;
    logic [`MEM_ADDR_WIDTH-1:0] pc_plus1;

    // Word addressing: sequential successor wraps naturally at the top.
    assign pc_plus1   = pc_q + `MEM_ADDR_WIDTH'(1);

    // Memory address comes straight from the PC register; no input reaches it.
    assign ins_addr_o = pc_q;

`ifndef FETCH_HALT_DETECT_EN
    assign halted_q = 1'b0;
`endif

    // Controller, PC and IF/ID register update.
    always_ff @(posedge clk_phase1_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= BOOT;
            pc_q            <= RESET_PC;
            ifid_pc_q       <= '0;
            ifid_pc_plus1_q <= '0;
            ifid_ins_q      <= NOP_WORD;
            ifid_valid_q    <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
            halted_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    // Stall and redirect are ignored for this single cycle.
                    pc_q         <= RESET_PC;
                    ifid_ins_q   <= NOP_WORD;
                    ifid_valid_q <= 1'b0;
                    state_q      <= RUN;
                end

                RUN: begin
                    if (redirect_i) begin
                        pc_q <= redirect_pc_i;
                    end else if (!stall_i) begin
                        pc_q <= pc_plus1;
                    end

                    // Bubble keeps the PC fields so downstream sees stable values.
                    if (redirect_i || flush_i) begin
                        ifid_ins_q   <= NOP_WORD;
                        ifid_valid_q <= 1'b0;
                    end else if (!stall_i) begin
                        ifid_pc_q       <= pc_q;
                        ifid_pc_plus1_q <= pc_plus1;
                        ifid_ins_q      <= ins_data_i;
                        ifid_valid_q    <= 1'b1;
`ifdef FETCH_HALT_DETECT_EN
                        // The halt word itself is still delivered as valid.
                        if (ins_data_i == {`DATA_WIDTH{1'b1}}) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
`endif
                    end
                end

                HALT: begin
                    ifid_ins_q   <= NOP_WORD;
                    ifid_valid_q <= 1'b0;
                    if (redirect_i) begin
                        pc_q     <= redirect_pc_i;
                        state_q  <= RUN;
`ifdef FETCH_HALT_DETECT_EN
                        halted_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q      <= BOOT;
                    ifid_ins_q   <= NOP_WORD;
                    ifid_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
